// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each output channel owns a one-entry
// register, so back-pressure on one channel only stalls beats addressed to it.
//
// Per-channel state (full[k]):
//   state | meaning
//   EMPTY | full=0, channel presents no beat
//   FULL  | full=1, channel holds a beat until out_ready_i[k]
module demux_1x4_stream #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [1:0]            sel_i,
  output logic [3:0]            out_valid_o,
  input  logic [3:0]            out_ready_i,
  output logic [DATA_WIDTH-1:0] out0_o,
  output logic [DATA_WIDTH-1:0] out1_o,
  output logic [DATA_WIDTH-1:0] out2_o,
  output logic [DATA_WIDTH-1:0] out3_o
);

  logic [3:0]            full_q;
  logic [3:0]            full_d;
  logic [3:0]            load;
  logic                  accept;
  logic [DATA_WIDTH-1:0] data_q [4];

  // Ready depends only on the addressed channel, never on in_valid_i.
  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    in_ready_o = ~full_q[sel_i] | out_ready_i[sel_i];
  end

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load[sel_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 4'b0000;
    end else begin
      full_q <= full_d;
    end
  end

  // A load always wins; otherwise a held beat stays until its ready arrives.
  always_comb begin
    full_d = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      full_d[k] = load[k] | (full_q[k] & ~out_ready_i[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          data_q[k] <= in_data_i;
        end
      end
    end
  end

  always_comb begin
    out_valid_o = full_q;
    out0_o      = data_q[0];
    out1_o      = data_q[1];
    out2_o      = data_q[2];
    out3_o      = data_q[3];
  end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Directed and random checks for demux_1x4_stream; inputs change 1ns after the
// rising edge, outputs are sampled on the falling edge or 1ns after the rise.
module tb_demux_1x4_stream;

  logic       clk_i;
  logic       rst_ni;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] in_data_i;
  logic [1:0] sel_i;
  logic [3:0] out_valid_o;
  logic [3:0] out_ready_i;
  logic [7:0] out0_o;
  logic [7:0] out1_o;
  logic [7:0] out2_o;
  logic [7:0] out3_o;

  int n_cmp;
  int n_err;

  demux_1x4_stream #(.DATA_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .sel_i       (sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out0_o      (out0_o),
    .out1_o      (out1_o),
    .out2_o      (out2_o),
    .out3_o      (out3_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] out_of(input int k);
    case (k)
      0:       return out0_o;
      1:       return out1_o;
      2:       return out2_o;
      default: return out3_o;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_data_i   = 8'($urandom);
      sel_i       = 2'(i % 4);
      out_ready_i = 4'($urandom);
      @(negedge clk_i);
      n_cmp++;
      if (out_valid_o !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_valid: got %b want 0000", out_valid_o);
      end
      n_cmp++;
      if ({out0_o, out1_o, out2_o, out3_o} !== 32'h0) begin
        n_err++;
        $display("FAIL reset_data: got %h want 00000000", {out0_o, out1_o, out2_o, out3_o});
      end
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready sel=%0d: got %b want 1", sel_i, in_ready_o);
      end
    end
    in_valid_i  = 1'b0;
    out_ready_i = 4'b0000;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_routing();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_valid_i = 1'b1;
      sel_i      = 2'(i);
      in_data_i  = vals[i];
      @(negedge clk_i);
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
        n_err++;
        $display("FAIL route_ready beat=%0d: got %b want 1", i, in_ready_o);
      end
      step();
      n_cmp++;
      if (out_valid_o !== 4'(1 << i)) begin
        n_err++;
        $display("FAIL route_valid beat=%0d: got %b want %b", i, out_valid_o, 4'(1 << i));
      end
      n_cmp++;
      if (out_of(i) !== vals[i]) begin
        n_err++;
        $display("FAIL route_data ch=%0d: got %h want %h", i, out_of(i), vals[i]);
      end
    end
    in_valid_i = 1'b0;
    step();
    n_cmp++;
    if (out_valid_o !== 4'b0000) begin
      n_err++;
      $display("FAIL route_drain: got %b want 0000", out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    out_ready_i = 4'b0000;
    in_valid_i  = 1'b1;
    sel_i       = 2'd2;
    in_data_i   = 8'hA5;
    @(negedge clk_i);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first_ready: got %b want 1", in_ready_o);
    end
    step();
    in_data_i = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (in_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL bp_blocked_ready cyc=%0d: got %b want 0", i, in_ready_o);
      end
      n_cmp++;
      if (out_valid_o !== 4'b0100 || out2_o !== 8'hA5) begin
        n_err++;
        $display("FAIL bp_hold cyc=%0d: got %b/%h want 0100/a5", i, out_valid_o, out2_o);
      end
      step();
    end
    out_ready_i = 4'b0100;
    @(negedge clk_i);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 4'b0100 || out2_o !== 8'h5A) begin
      n_err++;
      $display("FAIL bp_replace: got %b/%h want 0100/5a", out_valid_o, out2_o);
    end
    step();
    n_cmp++;
    if (out_valid_o !== 4'b0000 || out2_o !== 8'h5A) begin
      n_err++;
      $display("FAIL bp_drain_keep: got %b/%h want 0000/5a", out_valid_o, out2_o);
    end
    out_ready_i = 4'b0000;
  endtask

  task automatic test_isolation();
    out_ready_i = 4'b0000;
    in_valid_i  = 1'b1;
    sel_i       = 2'd1;
    in_data_i   = 8'h66;
    step();
    sel_i     = 2'd3;
    in_data_i = 8'h77;
    @(negedge clk_i);
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL iso_ready: got %b want 1", in_ready_o);
    end
    step();
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 4'b1010 || out3_o !== 8'h77 || out1_o !== 8'h66) begin
      n_err++;
      $display("FAIL iso_state: got %b/%h/%h want 1010/66/77", out_valid_o, out1_o, out3_o);
    end
    out_ready_i = 4'b1000;
    step();
    n_cmp++;
    if (out_valid_o !== 4'b0010 || out1_o !== 8'h66) begin
      n_err++;
      $display("FAIL iso_ch1_held: got %b/%h want 0010/66", out_valid_o, out1_o);
    end
    out_ready_i = 4'b1111;
    step();
    out_ready_i = 4'b0000;
  endtask

  task automatic test_reset_midop();
    out_ready_i = 4'b0000;
    in_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sel_i     = 2'(i);
      in_data_i = 8'hC0 + 8'(i);
      step();
    end
    in_valid_i = 1'b0;
    n_cmp++;
    if (out_valid_o !== 4'b0111) begin
      n_err++;
      $display("FAIL mid_filled: got %b want 0111", out_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (out_valid_o !== 4'b0000 || {out0_o, out1_o, out2_o} !== 24'h0) begin
      n_err++;
      $display("FAIL mid_async: got %b/%h want 0000/000000", out_valid_o, {out0_o, out1_o, out2_o});
    end
    #1;
    rst_ni = 1'b1;
    out_ready_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid_o !== 4'b0000) begin
        n_err++;
        $display("FAIL mid_after_release cyc=%0d: got %b want 0000", i, out_valid_o);
      end
    end
  endtask

  task automatic test_soak();
    logic [7:0] q [4][$];
    logic       stall_prev [4];
    logic [7:0] data_prev  [4];
    logic       pending;
    logic       acc;
    logic       exp_ready;
    int         errs_before;
    for (int k = 0; k < 4; k++) stall_prev[k] = 1'b0;
    pending    = 1'b0;
    in_valid_i = 1'b0;
    errs_before = n_err;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        in_valid_i = 1'($urandom_range(0, 1));
        sel_i      = 2'($urandom);
        in_data_i  = 8'($urandom);
      end
      out_ready_i = 4'($urandom);
      @(negedge clk_i);
      exp_ready = (q[sel_i].size() == 0) || out_ready_i[sel_i];
      n_cmp++;
      if (in_ready_o !== exp_ready && n_err - errs_before < 20) begin
        n_err++;
        $display("FAIL soak_ready cyc=%0d: got %b want %b", c, in_ready_o, exp_ready);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (out_valid_o[k] !== (q[k].size() != 0) && n_err - errs_before < 20) begin
          n_err++;
          $display("FAIL soak_valid cyc=%0d ch=%0d: got %b want %b", c, k, out_valid_o[k], q[k].size() != 0);
        end
        if (stall_prev[k]) begin
          n_cmp++;
          if ((out_valid_o[k] !== 1'b1 || out_of(k) !== data_prev[k]) && n_err - errs_before < 20) begin
            n_err++;
            $display("FAIL soak_stall cyc=%0d ch=%0d: got %b/%h want 1/%h", c, k, out_valid_o[k], out_of(k), data_prev[k]);
          end
        end
        if (q[k].size() != 0 && out_ready_i[k]) begin
          n_cmp++;
          if (out_of(k) !== q[k][0] && n_err - errs_before < 20) begin
            n_err++;
            $display("FAIL soak_data cyc=%0d ch=%0d: got %h want %h", c, k, out_of(k), q[k][0]);
          end
          void'(q[k].pop_front());
        end
        stall_prev[k] = out_valid_o[k] && !out_ready_i[k];
        data_prev[k]  = out_of(k);
      end
      acc = in_valid_i && exp_ready;
      if (acc) q[sel_i].push_back(in_data_i);
      pending = in_valid_i && !acc;
      step();
    end
    in_valid_i  = 1'b0;
    out_ready_i = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (out_valid_o[k] !== (q[k].size() != 0)) begin
        n_err++;
        $display("FAIL soak_final ch=%0d: got %b want %b", k, out_valid_o[k], q[k].size() != 0);
      end
      if (q[k].size() != 0) begin
        n_cmp++;
        if (out_of(k) !== q[k][0]) begin
          n_err++;
          $display("FAIL soak_final_data ch=%0d: got %h want %h", k, out_of(k), q[k][0]);
        end
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = 8'h00;
    sel_i       = 2'd0;
    out_ready_i = 4'b0000;
    test_reset();
    test_routing();
    test_back_to_back();
    test_isolation();
    test_reset_midop();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
